// File: rtl/instr_stream_encoder_pkg.sv
// instr_stream_encoder_pkg: shared opcode constants, FSM states and error codes
// for the 9-bit instruction stream writer.
package instr_stream_encoder_pkg;

    localparam logic [2:0] opLW    = 3'b000;
    localparam logic [2:0] opSW    = 3'b001;
    localparam logic [2:0] opADD   = 3'b010;
    localparam logic [2:0] opSUB   = 3'b011;
    localparam logic [2:0] opCEQ   = 3'b100;
    localparam logic [2:0] opCLT   = 3'b101;
    localparam logic [2:0] opSEI   = 3'b110;
    localparam logic [2:0] opOTHER = 3'b111;

    // Function codes reserved under OTHER; never emitted.
    localparam logic [2:0] fnB0 = 3'b110;
    localparam logic [2:0] fnB1 = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } enc_state_e;

    typedef enum logic [1:0] {
        E_NONE    = 2'b00,
        E_ILLEGAL = 2'b01,
        E_OVF     = 2'b10
    } enc_err_e;

endpackage

// File: rtl/instr_stream_encoder_packer.sv
// instr_field_packer: combinational field-to-word packing plus legality flag.
module instr_field_packer
    import instr_stream_encoder_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [2:0] i_fn,
    input  logic [2:0] i_ra,
    input  logic [2:0] i_rb,
    output logic [8:0] o_word,
    output logic       o_legal
);

    logic w_other;

    assign w_other = (i_op == opOTHER);
    // OTHER swaps rb out for the function code; SEI's imm6 is simply {ra,rb}.
    assign o_word  = w_other ? {opOTHER, i_fn, i_ra} : {i_op, i_ra, i_rb};
    assign o_legal = !(w_other && (i_fn == fnB0 || i_fn == fnB1));

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: streams packed instructions into memory at consecutive
// addresses through a one-entry output register, flagging illegal words and overflow.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [2:0]    in_fn,
    input  logic [2:0]    in_ra,
    input  logic [2:0]    in_rb,
    input  logic          in_last,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [8:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW:0]   count
);

    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    enc_state_e    r_state;
    enc_err_e      r_err_code;
    logic          r_full;
    logic          r_done;
    logic          r_err;
    logic [8:0]    r_word;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_count;

    logic [8:0]    w_word;
    logic          w_legal;
    logic          w_acc;
    logic          w_wr;
    logic          w_ovf;
    logic          w_restart;

    instr_field_packer u_pack (
        .i_op    (in_op),
        .i_fn    (in_fn),
        .i_ra    (in_ra),
        .i_rb    (in_rb),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign in_ready  = (r_state == LOAD) && (!r_full || mem_ready);
    assign w_acc     = in_valid && in_ready;
    assign w_wr      = r_full && mem_ready;
    // Written plus pending words; a pending word counts as already occupying memory.
    assign w_ovf     = (r_count + (AW+1)'(r_full)) == LIM;
    assign w_restart = start && (r_state == IDLE || r_state == DONE ||
                                 (r_state == ERR && !r_full));

    assign mem_we    = r_full;
    assign mem_wdata = r_word;
    assign mem_addr  = r_addr;
    assign count     = r_count;
    assign busy      = (r_state == LOAD) || (r_state == DRAIN);
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_full     <= 1'b0;
            r_word     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= E_NONE;
        end else begin
            if (w_wr) begin
                r_full  <= 1'b0;
                r_count <= r_count + (AW+1)'(1);
                // Hold at the top address; overflow is flagged before it could wrap.
                if (r_addr != '1) r_addr <= r_addr + AW'(1);
            end
            if (w_restart) begin
                r_state    <= LOAD;
                r_addr     <= '0;
                r_count    <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= E_NONE;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (w_acc) begin
                            if (!w_legal) begin
                                r_state    <= ERR;
                                r_err      <= 1'b1;
                                r_err_code <= E_ILLEGAL;
                            end else if (w_ovf) begin
                                r_state    <= ERR;
                                r_err      <= 1'b1;
                                r_err_code <= E_OVF;
                            end else begin
                                r_full <= 1'b1;
                                r_word <= w_word;
                                if (in_last) r_state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!r_full || w_wr) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    IDLE, DONE, ERR: r_state <= r_state;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: directed, table-driven checks of the instruction stream encoder
// (AW=8 instance for the main flow, AW=2 instance for overflow).
module tb_instr_stream_encoder;

    typedef struct {
        logic [2:0] op;
        logic [2:0] fn;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [8:0] word;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start, in_valid, in_last, mem_ready;
    logic [2:0] in_op, in_fn, in_ra, in_rb;
    logic       in_ready, mem_we, busy, done, err;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata;
    logic [1:0] err_code;
    logic [8:0] count;

    logic       b_start, b_in_valid, b_in_last, b_mem_ready;
    logic [2:0] b_in_op, b_in_fn, b_in_ra, b_in_rb;
    logic       b_in_ready, b_mem_we, b_busy, b_done, b_err;
    logic [1:0] b_mem_addr;
    logic [8:0] b_mem_wdata;
    logic [1:0] b_err_code;
    logic [2:0] b_count;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t tv[9];

    instr_stream_encoder #(.AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_fn(in_fn), .in_ra(in_ra), .in_rb(in_rb), .in_last(in_last),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    instr_stream_encoder #(.AW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op(b_in_op), .in_fn(b_in_fn), .in_ra(b_in_ra), .in_rb(b_in_rb), .in_last(b_in_last),
        .mem_we(b_mem_we), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic put(input logic [2:0] op, input logic [2:0] fn, input logic [2:0] ra,
                       input logic [2:0] rb, input logic last);
        in_valid = 1'b1;
        in_op = op; in_fn = fn; in_ra = ra; in_rb = rb; in_last = last;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        tv[0] = '{3'd2, 3'd0, 3'd1, 3'd1, 9'h089};
        tv[1] = '{3'd6, 3'd0, 3'd5, 3'd3, 9'h1AB};
        tv[2] = '{3'd0, 3'd0, 3'd7, 3'd0, 9'h038};
        tv[3] = '{3'd1, 3'd0, 3'd2, 3'd6, 9'h056};
        tv[4] = '{3'd3, 3'd0, 3'd3, 3'd4, 9'h0DC};
        tv[5] = '{3'd4, 3'd0, 3'd6, 3'd1, 9'h131};
        tv[6] = '{3'd5, 3'd0, 3'd0, 3'd7, 9'h147};
        tv[7] = '{3'd7, 3'd3, 3'd4, 3'd5, 9'h1DC};
        tv[8] = '{3'd7, 3'd5, 3'd2, 3'd7, 9'h1EA};

        rst_n = 1'b0;
        start = 0; in_valid = 0; in_last = 0; mem_ready = 0;
        in_op = 0; in_fn = 0; in_ra = 0; in_rb = 0;
        b_start = 0; b_in_valid = 0; b_in_last = 0; b_mem_ready = 0;
        b_in_op = 0; b_in_fn = 0; b_in_ra = 0; b_in_rb = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_count", count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_in_ready", in_ready, 0);

        // start and in_valid together in IDLE: start wins, tuple not taken
        start = 1'b1;
        put(tv[0].op, tv[0].fn, tv[0].ra, tv[0].rb, 1'b0);
        mem_ready = 1'b1;
        #1 chk("idle_start_in_ready", in_ready, 0);
        @(negedge clk); start = 1'b0;
        chk("start_no_accept", mem_we, 0);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            put(tv[i].op, tv[i].fn, tv[i].ra, tv[i].rb, i == 8);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), mem_we, 1);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, tv[i].word);
            chk($sformatf("vec%0d_addr", i), mem_addr, i);
            chk($sformatf("vec%0d_count", i), count, i);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("drain_in_ready", in_ready, 0);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_count", count, 9);
        chk("t1_we_idle", mem_we, 0);
        chk("t1_busy", busy, 0);

        // restart from DONE, then a write stalled by mem_ready=0
        pulse_start;
        chk("restart_count", count, 0);
        chk("restart_done", done, 0);
        chk("restart_addr", mem_addr, 0);
        mem_ready = 1'b0;
        put(3'd7, 3'd3, 3'd4, 3'd5, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_wdata", mem_wdata, 9'h1DC);
            chk("stall_we", mem_we, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_addr", mem_addr, 0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_count", count, 1);
        chk("stall_done_addr", mem_addr, 1);
        chk("stall_done_we", mem_we, 0);

        // start pulsed during LOAD is ignored
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("load_start_busy", busy, 1);
        chk("load_start_count", count, 1);
        chk("load_start_addr", mem_addr, 1);
        put(3'd0, 3'd0, 3'd7, 3'd0, 1'b1);
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk("t6_wdata", mem_wdata, 9'h038);
        chk("t6_addr", mem_addr, 1);
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_count", count, 2);

        // illegal second tuple
        pulse_start;
        put(3'd2, 3'd0, 3'd1, 3'd1, 1'b0);
        @(negedge clk);
        chk("ill_first_we", mem_we, 1);
        chk("ill_first_wdata", mem_wdata, 9'h089);
        put(3'd7, 3'd6, 3'd1, 3'd1, 1'b0);
        @(negedge clk);
        chk("ill_err", err, 1);
        chk("ill_code", err_code, 2'b01);
        chk("ill_we", mem_we, 0);
        chk("ill_count", count, 1);
        chk("ill_busy", busy, 0);
        put(3'd2, 3'd0, 3'd1, 3'd1, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        chk("err_no_accept", mem_we, 0);
        chk("err_hold_count", count, 1);
        chk("err_sticky", err_code, 2'b01);

        // asynchronous reset while a write is pending
        pulse_start;
        chk("err_restart", {err, err_code}, 0);
        put(3'd4, 3'd0, 3'd6, 3'd1, 1'b0);
        @(negedge clk);
        put(3'd5, 3'd0, 3'd0, 3'd7, 1'b0);
        @(negedge clk); in_valid = 1'b0; mem_ready = 1'b0;
        chk("pre_rst_we", mem_we, 1);
        chk("pre_rst_count", count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we", mem_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", count, 0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
        pulse_start;
        put(3'd1, 3'd0, 3'd2, 3'd6, 1'b1);
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wdata", mem_wdata, 9'h056);
        @(negedge clk);
        chk("post_rst_done", done, 1);

        // overflow on the AW=2 instance
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        b_mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1; b_in_op = 3'd0; b_in_ra = 3'(i); b_in_rb = 3'd0;
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("ovf%0d_we", i), b_mem_we, 1);
                chk($sformatf("ovf%0d_addr", i), b_mem_addr, i);
                chk($sformatf("ovf%0d_wdata", i), b_mem_wdata, {3'd0, 3'(i), 3'd0});
            end
        end
        b_in_valid = 1'b0;
        chk("ovf_err", b_err, 1);
        chk("ovf_code", b_err_code, 2'b10);
        chk("ovf_count", b_count, 4);
        chk("ovf_we", b_mem_we, 0);
        @(negedge clk);
        chk("ovf_we_after", b_mem_we, 0);
        chk("ovf_in_ready", b_in_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
